// File: rtl/xy_bin_sequencer_if.sv
// Signal bundle between the xy_bin sequencer, its three BRAM clients and the shared BRAM port.
// The sequencer takes the slave view. The environment (top level or bench) takes the master view.
interface xy_bin_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3
);
  logic              start;
  logic              sd_start;
  logic              sd_done;
  logic              cc_start;
  logic              cc_done;
  logic              vga_start;

  logic [ADDR_W-1:0] sd_addr;
  logic [DATA_W-1:0] sd_din;
  logic              sd_en;
  logic              sd_we;

  logic [ADDR_W-1:0] cc_addr;
  logic [DATA_W-1:0] cc_din;
  logic              cc_en;
  logic              cc_we;

  logic [ADDR_W-1:0] vga_addr;

  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_en;
  logic              bram_we;

  logic [2:0]        state_out;
  logic              error;

  modport slave (
    input  start, sd_done, cc_done,
    input  sd_addr, sd_din, sd_en, sd_we,
    input  cc_addr, cc_din, cc_en, cc_we,
    input  vga_addr,
    output sd_start, cc_start, vga_start,
    output bram_addr, bram_din, bram_en, bram_we,
    output state_out, error
  );

  modport master (
    output start, sd_done, cc_done,
    output sd_addr, sd_din, sd_en, sd_we,
    output cc_addr, cc_din, cc_en, cc_we,
    output vga_addr,
    input  sd_start, cc_start, vga_start,
    input  bram_addr, bram_din, bram_en, bram_we,
    input  state_out, error
  );
endinterface

// File: rtl/xy_bin_sequencer.sv
// Sequences LOAD -> CONTOUR -> DISPLAY over the shared xy_bin BRAM, with a hang watchdog.
// It owns the single BRAM port and grants it, registered, to whichever stage is active.
module xy_bin_sequencer #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 3,
  parameter int TIMEOUT = 2**24,
  parameter int TO_W    = 25
) (
  input  logic               clk,
  input  logic               reset,
  xy_bin_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CONTOUR = 3'd2,
    DISPLAY = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] WDOG_ONE  = TO_W'(1);

  state_t            state;
  state_t            next_state;
  logic              state_change;

  logic [TO_W-1:0]   wdog;
  logic              expired;

  logic              sd_start_q;
  logic              cc_start_q;
  logic              sd_accept;
  logic              cc_accept;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] din_d;
  logic              en_q;
  logic              en_d;
  logic              we_q;
  logic              we_d;

  logic [2:0]        state_out_q;

  // A done seen during the start-pulse cycle may be stale from the previous run.
  assign sd_accept    = bus.sd_done && !sd_start_q;
  assign cc_accept    = bus.cc_done && !cc_start_q;
  assign expired      = (TIMEOUT != 0) && (wdog == WDOG_LAST);
  assign state_change = (next_state != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) next_state = LOAD;
      end
      LOAD: begin
        if (sd_accept)    next_state = CONTOUR;
        else if (expired) next_state = FAULT;
      end
      CONTOUR: begin
        if (cc_accept)    next_state = DISPLAY;
        else if (expired) next_state = FAULT;
      end
      DISPLAY: begin
        if (bus.start) next_state = LOAD;
      end
      FAULT: begin
        if (bus.start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Owner selection; a state change forces one dead cycle with en/we low.
  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    en_d   = 1'b0;
    we_d   = 1'b0;
    if (!state_change) begin
      case (state)
        LOAD: begin
          addr_d = bus.sd_addr;
          din_d  = bus.sd_din;
          en_d   = bus.sd_en;
          we_d   = bus.sd_we;
        end
        CONTOUR: begin
          addr_d = bus.cc_addr;
          din_d  = bus.cc_din;
          en_d   = bus.cc_en;
          we_d   = bus.cc_we;
        end
        DISPLAY: begin
          addr_d = bus.vga_addr;
          din_d  = '0;
          en_d   = 1'b1;
          we_d   = 1'b0;
        end
        default: begin
          addr_d = addr_q;
          din_d  = din_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (state_change) begin
      wdog <= '0;
    end else if ((TIMEOUT != 0) && ((state == LOAD) || (state == CONTOUR))) begin
      wdog <= wdog + WDOG_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_start_q  <= 1'b0;
      cc_start_q  <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      state_out_q <= 3'd0;
    end else begin
      sd_start_q  <= (next_state == LOAD) && (state != LOAD);
      cc_start_q  <= (next_state == CONTOUR) && (state != CONTOUR);
      addr_q      <= addr_d;
      din_q       <= din_d;
      en_q        <= en_d;
      we_q        <= we_d;
      state_out_q <= state;
    end
  end

  assign bus.sd_start  = sd_start_q;
  assign bus.cc_start  = cc_start_q;
  assign bus.vga_start = (state == DISPLAY);
  assign bus.error     = (state == FAULT);
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign bus.bram_en   = en_q;
  assign bus.bram_we   = we_q;
  assign bus.state_out = state_out_q;

endmodule
